// File: rtl/booth_mult_arbiter_pkg.sv
// Shared types and constants for the Booth multiplier arbiter.
// FSM encoding and the multiplier timeout length.
package booth_mult_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BUSY,
        S_RESP
    } state_t;

    // BUSY cycles allowed before a job is declared failed
    function automatic int tmo_cycles(input int nb);
        return (1 << nb) + 2;
    endfunction

endpackage

// File: rtl/booth_rr_arbiter.sv
// Combinational round-robin picker.
// First set request at or above ptr, wrapping at NREQ-1.
module booth_rr_arbiter
    import booth_mult_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any_gnt
);

    localparam logic [IDW:0] NR = (IDW+1)'(NREQ);

    logic [IDW:0] sum;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        any_gnt = 1'b0;
        sum     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IDW+1)'(i);
            if (sum >= NR) sum = sum - NR;
            if (!any_gnt && req[sum[IDW-1:0]]) begin
                any_gnt             = 1'b1;
                gnt[sum[IDW-1:0]]   = 1'b1;
                gnt_id              = sum[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one sequential Booth multiplier between NREQ requesters.
// Round-robin grant, load/run/done sequencing, tagged response.
module booth_mult_arbiter
    import booth_mult_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int Nb   = 2,
    localparam int N    = 2**Nb,
    parameter  int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_m,
    input  logic [NREQ*N-1:0] req_q,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*N-1:0]    rsp_p,
    output logic              rsp_err,
    output logic              mul_ld,
    output logic [N-1:0]      mul_im,
    output logic [N-1:0]      mul_iq,
    input  logic              mul_pd,
    input  logic [2*N-1:0]    mul_p
);

    localparam int             CW       = $clog2(N+3);
    localparam int             TMO      = tmo_cycles(Nb);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TMO-1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ-1);

    state_t          state, nstate;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id_q;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            any_gnt;
    logic [N-1:0]    sel_m;
    logic [N-1:0]    sel_q;

    booth_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .any_gnt (any_gnt)
    );

    always_comb begin
        sel_m = '0;
        sel_q = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_m = req_m[i*N +: N];
                sel_q = req_q[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= nstate;
    end

    always_comb begin
        nstate    = state;
        req_ready = '0;
        mul_ld    = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = gnt;
                if (any_gnt) nstate = S_LOAD;
            end
            S_LOAD: begin
                mul_ld = 1'b1;
                nstate = S_BUSY;
            end
            S_BUSY: begin
                if (mul_pd || cnt == CNT_LAST) nstate = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) nstate = S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr     <= '0;
            id_q    <= '0;
            cnt     <= '0;
            mul_im  <= '0;
            mul_iq  <= '0;
            rsp_p   <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (state == S_IDLE && any_gnt) begin
                id_q   <= gnt_id;
                mul_im <= sel_m;
                mul_iq <= sel_q;
            end
            if (state == S_LOAD) cnt <= '0;
            // mul_p is only trustworthy in the mul_pd cycle
            if (state == S_BUSY) begin
                cnt <= cnt + 1'b1;
                if (mul_pd) begin
                    rsp_p   <= mul_p;
                    rsp_err <= 1'b0;
                end else if (cnt == CNT_LAST) begin
                    rsp_p   <= '0;
                    rsp_err <= 1'b1;
                end
            end
            if (state == S_RESP && rsp_ready) begin
                ptr <= (id_q == LAST_ID) ? '0 : id_q + 1'b1;
            end
        end
    end

    assign rsp_id = id_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench for booth_mult_arbiter with a stand-in multiplier.
// Transaction-level model checked every cycle plus literal expectations.
module tb_booth_mult_arbiter;

    localparam int NREQ = 4;
    localparam int Nb   = 2;
    localparam int N    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_m;
    logic [NREQ*N-1:0] req_q;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*N-1:0]    rsp_p;
    logic              rsp_err;
    logic              mul_ld;
    logic [N-1:0]      mul_im;
    logic [N-1:0]      mul_iq;
    logic              mul_pd;
    logic [2*N-1:0]    mul_p;

    booth_mult_arbiter #(
        .NREQ (NREQ),
        .Nb   (Nb)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_m     (req_m),
        .req_q     (req_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .rsp_err   (rsp_err),
        .mul_ld    (mul_ld),
        .mul_im    (mul_im),
        .mul_iq    (mul_iq),
        .mul_pd    (mul_pd),
        .mul_p     (mul_p)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic rst_pos = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_pos <= rst;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int sx(input logic [N-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [2*N-1:0] sprod(input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        return (2*N)'(sx(a) * sx(b));
    endfunction

    // stand-in multiplier: pd exactly N cycles after the ld cycle
    logic           mpd = 1'b0;
    logic           spur = 1'b0;
    logic           stuck = 1'b0;
    logic [2*N-1:0] mp = '0;
    logic [N-1:0]   ma = '0;
    logic [N-1:0]   mb = '0;
    int             rem = 0;
    logic           mbz = 1'b0;

    assign mul_pd = mpd | spur;
    assign mul_p  = mp;

    always @(posedge clk) begin
        if (!rst) begin
            mbz <= 1'b0;
            rem <= 0;
            mpd <= 1'b0;
            mp  <= '0;
        end else begin
            mpd <= 1'b0;
            mp  <= (2*N)'($urandom);
            if (mul_ld) begin
                ma  <= mul_im;
                mb  <= mul_iq;
                rem <= N - 1;
                mbz <= 1'b1;
            end else if (mbz) begin
                if (rem == 1) begin
                    mbz <= 1'b0;
                    if (!stuck) begin
                        mpd <= 1'b1;
                        mp  <= sprod(ma, mb);
                    end
                end
                rem <= rem - 1;
            end
        end
    end

    typedef struct packed {
        int             id;
        logic [2*N-1:0] p;
        logic           err;
        int             hs;
        int             rise;
        int             acc;
    } rec_t;

    rec_t rlog[$];
    int   gq[$];

    logic [IDW-1:0] mptr  = '0;
    logic           mbusy = 1'b0;
    logic           inrsp = 1'b0;
    logic           merr  = 1'b0;
    logic [IDW-1:0] mid   = '0;
    logic [2*N-1:0] mprod = '0;
    logic [N-1:0]   mm    = '0;
    logic [N-1:0]   mq    = '0;
    int             hs_cyc = -10;
    int             rise_cyc = -10;

    function automatic logic [NREQ-1:0] exp_gnt(input logic [NREQ-1:0] v,
                                               input int p);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (v[j]) return NREQ'(1) << j;
        end
        return '0;
    endfunction

    // compare process: transaction-level model, checked every cycle
    initial begin
        logic [NREQ-1:0] hsv;
        forever begin
            @(negedge clk);
            if (!rst_pos) begin
                mbusy = 1'b0;
                inrsp = 1'b0;
                mptr  = '0;
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_id", rsp_id, 0);
                chk("rst_rsp_p", rsp_p, 0);
                chk("rst_rsp_err", rsp_err, 0);
                chk("rst_mul_ld", mul_ld, 0);
                chk("rst_mul_im", mul_im, 0);
                chk("rst_mul_iq", mul_iq, 0);
            end
            chk("req_ready", req_ready,
                mbusy ? '0 : exp_gnt(req_valid, int'(mptr)));
            chk("mul_ld", mul_ld, mbusy && cyc == hs_cyc + 1);
            if (mbusy && cyc == hs_cyc + 1) begin
                chk("mul_im", mul_im, mm);
                chk("mul_iq", mul_iq, mq);
            end
            if (!mbusy) begin
                chk("rsp_valid_idle", rsp_valid, 0);
            end else if (!inrsp) begin
                chk("rsp_valid_rise", rsp_valid, cyc == rise_cyc);
                if (rsp_valid && cyc == rise_cyc) inrsp = 1'b1;
            end
            if (inrsp) begin
                chk("rsp_valid_hold", rsp_valid, 1);
                chk("rsp_id", rsp_id, mid);
                chk("rsp_p", rsp_p, mprod);
                chk("rsp_err", rsp_err, merr);
                if (rst && rsp_ready) begin
                    rlog.push_back('{int'(mid), mprod, merr,
                                     hs_cyc, rise_cyc, cyc});
                    mptr  = IDW'((int'(mid) + 1) % NREQ);
                    mbusy = 1'b0;
                    inrsp = 1'b0;
                end
            end
            hsv = req_valid & req_ready;
            if (rst && !mbusy && hsv != '0) begin
                for (int j = 0; j < NREQ; j++) begin
                    if (hsv[j]) mid = IDW'(j);
                end
                mm       = req_m[int'(mid)*N +: N];
                mq       = req_q[int'(mid)*N +: N];
                merr     = stuck;
                mprod    = stuck ? '0 : sprod(mm, mq);
                hs_cyc   = cyc;
                rise_cyc = cyc + (stuck ? N + 4 : N + 2);
                mbusy    = 1'b1;
                gq.push_back(int'(mid));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setop(input int i, input int m, input int q);
        req_m[i*N +: N] = N'(m);
        req_q[i*N +: N] = N'(q);
        req_valid[i]    = 1'b1;
    endtask

    task automatic grab(input int i);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge clk);
            if (rst && req_ready[i]) got = 1'b1;
        end
        chk("grant_wait", got, 1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic send(input int i, input int m, input int q);
        setop(i, m, q);
        grab(i);
    endtask

    task automatic wait_rsp(input int n);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            step();
            if (rlog.size() >= n) ok = 1'b1;
        end
        chk("rsp_wait", ok, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b;
        int g;
        logic [NREQ-1:0] hsv;
        logic [2*N-1:0] t2p [4];
        int t3g [5];
        logic seen;
        t2p = '{8'hFA, 8'hDD, 8'h24, 8'hFF};
        t3g = '{1, 3, 0, 1, 3};
        req_valid = '0;
        req_m     = '0;
        req_q     = '0;
        rsp_ready = 1'b1;
        rst       = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // single job, 3 x 5
        b = rlog.size();
        send(0, 3, 5);
        wait_rsp(b + 1);
        chk("t1_p", rlog[b].p, 8'h0F);
        chk("t1_id", rlog[b].id, 0);
        chk("t1_err", rlog[b].err, 0);
        chk("t1_lat", rlog[b].rise - rlog[b].hs, 6);

        // all four valid out of reset
        rst       = 1'b0;
        req_m     = {4'h1, 4'h6, 4'h9, 4'hE};
        req_q     = {4'hF, 4'h6, 4'h5, 4'h3};
        req_valid = 4'hF;
        step();
        step();
        b = rlog.size();
        g = gq.size();
        rst = 1'b1;
        for (int k = 0; k < 200 && req_valid != '0; k++) begin
            @(negedge clk);
            hsv = req_valid & req_ready;
            if (rst && hsv != '0) begin
                @(posedge clk);
                #1;
                req_valid = req_valid & ~hsv;
            end
        end
        chk("t2_drain", req_valid, 0);
        wait_rsp(b + 4);
        for (int k = 0; k < 4; k++) begin
            chk("t2_id", gq[g+k], k);
            chk("t2_p", rlog[b+k].p, t2p[k]);
        end
        chk("t2_rate", rlog[b+1].hs - rlog[b].hs, 7);

        // fairness between 1 and 3, late arrival of 0
        b = rlog.size();
        g = gq.size();
        setop(1, 2, -3);
        setop(3, -4, -4);
        wait_rsp(b + 1);
        setop(0, 7, 7);
        for (int k = 0; k < 300 && gq.size() < g + 5; k++) begin
            @(negedge clk);
            if (rst && req_ready[0]) begin
                @(posedge clk);
                #1;
                req_valid[0] = 1'b0;
            end
        end
        step();
        req_valid = '0;
        wait_rsp(b + 5);
        for (int k = 0; k < 5; k++) chk("t3_order", gq[g+k], t3g[k]);

        // backpressure for five cycles
        b = rlog.size();
        rsp_ready = 1'b0;
        send(2, 5, -2);
        setop(1, 1, 1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("t4_rise", seen, 1);
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        grab(1);
        wait_rsp(b + 2);
        chk("t4_p", rlog[b].p, 8'hF6);
        chk("t4_hold", rlog[b].acc - rlog[b].rise, 5);
        chk("t4_next_id", rlog[b+1].id, 1);

        // reset while the multiplier is running
        b = rlog.size();
        send(0, 5, 5);
        repeat (3) step();
        rst = 1'b0;
        step();
        rst  = 1'b1;
        spur = 1'b1;
        step();
        spur = 1'b0;
        repeat (3) step();
        chk("t5_abandon", rlog.size(), b);
        send(1, 2, 2);
        wait_rsp(b + 1);
        chk("t5_p", rlog[b].p, 8'h04);
        chk("t5_id", rlog[b].id, 1);

        // multiplier never signals done
        b = rlog.size();
        stuck = 1'b1;
        send(2, 3, 3);
        wait_rsp(b + 1);
        stuck = 1'b0;
        chk("t6_err", rlog[b].err, 1);
        chk("t6_p", rlog[b].p, 0);
        chk("t6_lat", rlog[b].rise - rlog[b].hs, N + 4);
        send(3, -3, 2);
        wait_rsp(b + 2);
        chk("t6_next_p", rlog[b+1].p, 8'hFA);
        chk("t6_next_err", rlog[b+1].err, 0);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
Shares one sequential radix-2 Booth multiplier between NREQ requesters. Each requester has a valid/ready operand port. A round-robin arbiter picks the next job and sequences the multiplier through load, run and done. The product is returned on a single tagged valid/ready response port. The block sits between the requesting datapaths and the multiplier instance, which it drives through its ld/im/iq/pd/p pins.

Parameters:
NREQ, 4, number of requesters (2..8)
Nb, 2, log2 of operand width; multiplier run length is N=2**Nb cycles
N, 2**Nb, operand width in bits (derived; do not override)
IDW, $clog2(NREQ), requester id width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_m  in  NREQ*N  packed multiplicands, two's complement; requester i uses slice [i*N +: N]
req_q  in  NREQ*N  packed multipliers, two's complement, same packing
rsp_valid  out  1  product valid
rsp_ready  in  1  consumer accepts product
rsp_id  out  IDW  index of the requester that owns the product
rsp_p  out  2N  signed product
rsp_err  out  1  multiplier timed out; rsp_p forced to 0
mul_ld  out  1  one-cycle load strobe to multiplier
mul_im  out  N  multiplicand to multiplier
mul_iq  out  N  multiplier operand to multiplier
mul_pd  in  1  multiplier done pulse
mul_p  in  2N  multiplier product

Behaviour:
- Reset (rst=0 at posedge) puts the block in IDLE.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_p=0, rsp_err=0.
  - mul_ld=0, mul_im=0, mul_iq=0.
  - Round-robin pointer=0, timeout counter=0.
  - Reset mid-operation abandons the job. No response is issued for it.
- Multiplier contract:
  - mul_ld high for one cycle loads the operands.
  - mul_pd is high for exactly one cycle, N cycles after the ld cycle.
  - mul_p is valid only in that cycle.
  - mul_pd outside BUSY is spurious and is ignored. This includes pulses caused by the multiplier's own reset.
- FSM states: IDLE, LOAD, BUSY, RESP.
- IDLE:
  - Grant = first requester with req_valid, searching from the pointer upward and wrapping at NREQ-1.
  - req_ready[grant]=1, combinational from req_valid and the pointer. All other ready bits are 0.
  - On handshake: register that requester's m and q into mul_im/mul_iq, store the id, go to LOAD.
  - With no valid request, stay in IDLE.
- LOAD: mul_ld=1 for this single cycle. Clear the timeout counter. Go to BUSY.
- BUSY:
  - mul_ld=0; count cycles.
  - When mul_pd=1: capture mul_p into rsp_p, set rsp_err=0, go to RESP.
  - When the count reaches N+2 without mul_pd: set rsp_p=0, rsp_err=1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_p and rsp_err are held stable until rsp_ready=1.
  - On accept: pointer = stored id + 1 (mod NREQ), rsp_valid drops next cycle, go to IDLE.
- Latency: rsp_valid rises N+2 cycles after the request handshake cycle.
- Throughput: with rsp_ready held high, one job every N+3 cycles.
- No request is accepted outside IDLE, so req_ready=0 in LOAD, BUSY and RESP.
- A requester that drops req_valid before being granted is simply skipped. No state is kept per requester.
- mul_im and mul_iq hold their last operands after the job completes.

Decomposition:
- Shared package: FSM state enum (IDLE, LOAD, BUSY, RESP) and the timeout constant (N+2).
- One sub-module: booth_rr_arbiter.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and its encoded index.
  - Purely combinational. The pointer register stays in the top level.
- The Booth multiplier is instantiated by the parent, not inside this block.

Test Plan:
1. Nb=2, single job: requester 0 sends m=3, q=5 with a real multiplier attached -> rsp_valid 6 cycles after handshake, rsp_p=8'h0F, rsp_id=0, rsp_err=0.
2. All four requesters valid from reset with distinct operands (-2×3, -7×5, 6×6, 1×-1) -> grants in order 0,1,2,3. Products 8'hFA, 8'hDD, 8'h24, 8'hFF with matching ids. Jobs start every 7 cycles.
3. Fairness: requesters 1 and 3 held valid continuously -> grants alternate 1,3,1,3. Requester 0 raises valid after the first job -> it is served after the next completion at which the pointer lets it win.
4. Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_p and rsp_id stay stable, req_ready stays 0. Accept on cycle 6 -> IDLE on the next cycle.
5. Reset mid-BUSY: rst=0 for 1 cycle, with the multiplier also reset -> all outputs at reset values, no response for the abandoned job. A spurious mul_pd after reset is ignored. The next job 2×2 returns 8'h04.
6. Timeout: mul_pd stuck low -> rsp_valid with rsp_err=1 and rsp_p=0, N+2 cycles after entering BUSY. The next job with a healthy multiplier completes normally.
